// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the execution sequencer: FSM state encoding and
// the default counter width.
package exec_sequencer_pkg;

    localparam int SEQ_CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXEC    = 3'd3,
        S_MEMWAIT = 3'd4,
        S_DONE    = 3'd5
    } seq_state_t;

endpackage

// File: rtl/exec_sequencer_if.sv
// Control bundle between the sequencer and the rest of the 9-bit datapath:
// decoder flags and Start in, datapath strobes and status counters out.
interface exec_sequencer_if
    import exec_sequencer_pkg::*;
#(
    parameter int CNT_W = SEQ_CNT_W
);
    logic             Start;
    logic             BranchEn;
    logic             RegWrEn;
    logic             MemWrEn;
    logic             LoadInst;
    logic             AckInst;
    logic             Taken;
    logic             PcClear;
    logic             FetchEn;
    logic             IrLoad;
    logic             PcInc;
    logic             PcBranch;
    logic             RegWe;
    logic             MemWe;
    logic             MemRe;
    logic             Busy;
    logic             Done;
    logic [CNT_W-1:0] InstCount;
    logic [CNT_W-1:0] CycleCount;

    // The sequencer side drives the strobes.
    modport master (
        input  Start, BranchEn, RegWrEn, MemWrEn, LoadInst, AckInst, Taken,
        output PcClear, FetchEn, IrLoad, PcInc, PcBranch, RegWe, MemWe, MemRe,
        output Busy, Done, InstCount, CycleCount
    );

    modport slave (
        output Start, BranchEn, RegWrEn, MemWrEn, LoadInst, AckInst, Taken,
        input  PcClear, FetchEn, IrLoad, PcInc, PcBranch, RegWe, MemWe, MemRe,
        input  Busy, Done, InstCount, CycleCount
    );

endinterface

// File: rtl/exec_sequencer_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clr wins over inc.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer with load wait states, the
// Start/Done program handshake and saturating retire/cycle counters.
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = SEQ_CNT_W
) (
    input  logic             Clk,
    input  logic             Reset,
    exec_sequencer_if.master bus
);

    localparam int WAIT_W = $clog2(MEM_LAT + 1);

    seq_state_t        state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;

    logic pc_clear, fetch_en, ir_load, pc_inc, pc_branch;
    logic reg_we, mem_we, mem_re, busy, done;
    logic take;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg    <= S_IDLE;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    assign take = bus.BranchEn & bus.Taken;

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        pc_clear      = 1'b0;
        fetch_en      = 1'b0;
        ir_load       = 1'b0;
        pc_inc        = 1'b0;
        pc_branch     = 1'b0;
        reg_we        = 1'b0;
        mem_we        = 1'b0;
        mem_re        = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state_reg)
            S_IDLE: begin
                // Suppress the clear pulse while Reset holds the block idle.
                if (bus.Start && !Reset) begin
                    pc_clear   = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                busy       = 1'b1;
                fetch_en   = 1'b1;
                ir_load    = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                busy       = 1'b1;
                state_next = bus.AckInst ? S_DONE : S_EXEC;
            end
            S_EXEC: begin
                busy = 1'b1;
                if (bus.LoadInst) begin
                    mem_re        = 1'b1;
                    wait_cnt_next = WAIT_W'(MEM_LAT - 1);
                    state_next    = S_MEMWAIT;
                end else begin
                    reg_we     = bus.RegWrEn & ~bus.BranchEn;
                    mem_we     = bus.MemWrEn;
                    pc_branch  = take;
                    pc_inc     = ~take;
                    state_next = S_FETCH;
                end
            end
            S_MEMWAIT: begin
                busy   = 1'b1;
                mem_re = 1'b1;
                // Read data is valid once the wait count has run down.
                if (wait_cnt_reg == '0) begin
                    reg_we     = 1'b1;
                    pc_inc     = 1'b1;
                    state_next = S_FETCH;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 1'b1;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (!bus.Start) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Index 0 counts retired instructions, index 1 counts busy cycles.
    logic             cnt_clr;
    logic             cnt_inc [2];
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_clr    = Reset | pc_clear;
    assign cnt_inc[0] = pc_inc | pc_branch;
    assign cnt_inc[1] = busy;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            sat_counter #(.W(CNT_W)) u_cnt (
                .clk   (Clk),
                .clr   (cnt_clr),
                .inc   (cnt_inc[gi]),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign bus.PcClear    = pc_clear;
    assign bus.FetchEn    = fetch_en;
    assign bus.IrLoad     = ir_load;
    assign bus.PcInc      = pc_inc;
    assign bus.PcBranch   = pc_branch;
    assign bus.RegWe      = reg_we;
    assign bus.MemWe      = mem_we;
    assign bus.MemRe      = mem_re;
    assign bus.Busy       = busy;
    assign bus.Done       = done;
    assign bus.InstCount  = cnt_val[0];
    assign bus.CycleCount = cnt_val[1];

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: per-instruction expected strobe timelines and
// unbounded counter totals, checked against a 16-bit and a 4-bit instance.
module tb_exec_sequencer;

    localparam int MEM_LAT = 2;

    localparam logic [9:0] M_CLR  = 10'b10_0000_0000;
    localparam logic [9:0] M_FE   = 10'b01_0000_0000;
    localparam logic [9:0] M_IR   = 10'b00_1000_0000;
    localparam logic [9:0] M_INC  = 10'b00_0100_0000;
    localparam logic [9:0] M_BR   = 10'b00_0010_0000;
    localparam logic [9:0] M_RWE  = 10'b00_0001_0000;
    localparam logic [9:0] M_MWE  = 10'b00_0000_1000;
    localparam logic [9:0] M_MRE  = 10'b00_0000_0100;
    localparam logic [9:0] M_BUSY = 10'b00_0000_0010;
    localparam logic [9:0] M_DONE = 10'b00_0000_0001;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    exec_sequencer_if #(.CNT_W(16)) bus ();
    exec_sequencer_if #(.CNT_W(4))  bus_s ();

    assign bus_s.Start    = bus.Start;
    assign bus_s.BranchEn = bus.BranchEn;
    assign bus_s.RegWrEn  = bus.RegWrEn;
    assign bus_s.MemWrEn  = bus.MemWrEn;
    assign bus_s.LoadInst = bus.LoadInst;
    assign bus_s.AckInst  = bus.AckInst;
    assign bus_s.Taken    = bus.Taken;

    exec_sequencer #(.MEM_LAT(MEM_LAT), .CNT_W(16)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    exec_sequencer #(.MEM_LAT(MEM_LAT), .CNT_W(4)) dut_s (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus_s)
    );

    logic [9:0] act_vec, act_vec_s;
    assign act_vec   = {bus.PcClear, bus.FetchEn, bus.IrLoad, bus.PcInc, bus.PcBranch,
                        bus.RegWe, bus.MemWe, bus.MemRe, bus.Busy, bus.Done};
    assign act_vec_s = {bus_s.PcClear, bus_s.FetchEn, bus_s.IrLoad, bus_s.PcInc, bus_s.PcBranch,
                        bus_s.RegWe, bus_s.MemWe, bus_s.MemRe, bus_s.Busy, bus_s.Done};

    int     total = 0;
    int     bad   = 0;
    longint inst_m = 0;
    longint cyc_m  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] sat(input longint v, input int w);
        longint lim;
        lim = (longint'(1) << w) - 1;
        return (v > lim) ? 32'(lim) : 32'(v);
    endfunction

    // One clock cycle: inputs already applied; compare mid-cycle, then advance model.
    task automatic step(input logic [9:0] exp, input logic rst_in, input string tag);
        Reset = rst_in;
        @(negedge Clk);
        check({tag, ".out"},   {22'd0, act_vec},   {22'd0, exp});
        check({tag, ".out4"},  {22'd0, act_vec_s}, {22'd0, exp});
        check({tag, ".inst"},  32'(bus.InstCount),    sat(inst_m, 16));
        check({tag, ".cyc"},   32'(bus.CycleCount),   sat(cyc_m, 16));
        check({tag, ".inst4"}, 32'(bus_s.InstCount),  sat(inst_m, 4));
        check({tag, ".cyc4"},  32'(bus_s.CycleCount), sat(cyc_m, 4));
        if (rst_in || exp[9]) begin
            inst_m = 0;
            cyc_m  = 0;
        end else begin
            if ((exp & M_BUSY) != 0) cyc_m++;
            if ((exp & (M_INC | M_BR)) != 0) inst_m++;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic scramble_flags();
        bus.BranchEn = 1'($urandom);
        bus.RegWrEn  = 1'($urandom);
        bus.MemWrEn  = 1'($urandom);
        bus.LoadInst = 1'($urandom);
        bus.AckInst  = 1'($urandom);
        bus.Taken    = 1'($urandom);
    endtask

    task automatic begin_program();
        bus.Start = 1'b1;
        step(M_CLR, 1'b0, "start");
    endtask

    // Fetch with junk flags (must be ignored), then hold the real flags.
    task automatic run_instr(input logic b, input logic rw, input logic mw,
                             input logic ld, input logic tk);
        logic [9:0] e;
        scramble_flags();
        bus.Start = 1'($urandom);
        step(M_FE | M_IR | M_BUSY, 1'b0, "fetch");
        bus.BranchEn = b;
        bus.RegWrEn  = rw;
        bus.MemWrEn  = mw;
        bus.LoadInst = ld;
        bus.AckInst  = 1'b0;
        bus.Taken    = tk;
        bus.Start    = 1'($urandom);
        step(M_BUSY, 1'b0, "decode");
        if (ld) begin
            step(M_MRE | M_BUSY, 1'b0, "exec_ld");
            for (int i = 1; i <= MEM_LAT; i++) begin
                e = M_MRE | M_BUSY;
                if (i == MEM_LAT) e = e | M_RWE | M_INC;
                step(e, 1'b0, "memwait");
            end
        end else begin
            e = M_BUSY;
            e = e | ((b & tk) ? M_BR : M_INC);
            if (rw && !b) e = e | M_RWE;
            if (mw) e = e | M_MWE;
            step(e, 1'b0, "exec");
        end
        $display("instr b=%0b rw=%0b mw=%0b ld=%0b tk=%0b inst=%0d cyc=%0d",
                 b, rw, mw, ld, tk, inst_m, cyc_m);
    endtask

    task automatic run_random(input int n);
        for (int k = 0; k < n; k++) begin
            run_instr(1'($urandom), 1'($urandom), 1'($urandom),
                      ($urandom_range(3) == 0), 1'($urandom));
        end
    endtask

    task automatic finish_program(input int hold);
        scramble_flags();
        step(M_FE | M_IR | M_BUSY, 1'b0, "fetch_ack");
        scramble_flags();
        bus.AckInst = 1'b1;
        step(M_BUSY, 1'b0, "decode_ack");
        bus.Start = 1'b1;
        for (int k = 0; k < hold; k++) begin
            scramble_flags();
            step(M_DONE, 1'b0, "done_hold");
        end
        bus.Start = 1'b0;
        step(M_DONE, 1'b0, "done_rel");
        step(10'd0, 1'b0, "idle");
        $display("program done inst=%0d cyc=%0d", inst_m, cyc_m);
    endtask

    initial begin
        Reset        = 1'b1;
        bus.Start    = 1'b0;
        bus.BranchEn = 1'b0;
        bus.RegWrEn  = 1'b0;
        bus.MemWrEn  = 1'b0;
        bus.LoadInst = 1'b0;
        bus.AckInst  = 1'b0;
        bus.Taken    = 1'b0;
        @(posedge Clk);
        #1;
        step(10'd0, 1'b1, "reset");
        step(10'd0, 1'b0, "idle0");

        begin_program();
        run_instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_instr(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        run_instr(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        run_instr(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_random(20);
        finish_program(5);

        begin_program();
        run_random(25);
        finish_program($urandom_range(1, 4));

        // Reset in the first wait cycle of a load.
        begin_program();
        scramble_flags();
        bus.Start = 1'b0;
        step(M_FE | M_IR | M_BUSY, 1'b0, "fetch_r");
        bus.LoadInst = 1'b1;
        bus.AckInst  = 1'b0;
        step(M_BUSY, 1'b0, "decode_r");
        step(M_MRE | M_BUSY, 1'b0, "exec_r");
        step(M_MRE | M_BUSY, 1'b1, "memwait_rst");
        step(10'd0, 1'b0, "after_rst");
        step(10'd0, 1'b0, "after_rst2");

        begin_program();
        for (int k = 0; k < 12; k++) run_instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_random(15);
        finish_program(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
Multi-cycle execution sequencer for the 9-bit processor. It takes the static decode flags from the control decoder and the ALU branch condition, and steps each instruction through fetch, decode, execute and optional memory wait. It drives the PC, instruction register, register-file and data-memory strobes. It also implements the Start/Done program handshake and keeps retire and cycle counters for the bench.

Parameters:
MEM_LAT, 2, data-memory read latency in cycles for loads (legal range >=1)
CNT_W, 16, width of InstCount and CycleCount

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high; returns block to IDLE
Start  input  1  level request to run a program from PC 0
BranchEn  input  1  decoder: instruction is a conditional branch
RegWrEn  input  1  decoder: instruction writes the register file
MemWrEn  input  1  decoder: instruction is a store
LoadInst  input  1  decoder: instruction is a load
AckInst  input  1  decoder: instruction is the all-ones done instruction
Taken  input  1  ALU branch condition, valid during EXEC
PcClear  output  1  pulse: zero the program counter
FetchEn  output  1  instruction ROM read enable
IrLoad  output  1  instruction register capture
PcInc  output  1  PC <= PC+1
PcBranch  output  1  PC <= branch target
RegWe  output  1  register-file write strobe
MemWe  output  1  data-memory write strobe
MemRe  output  1  data-memory read enable
Busy  output  1  high in FETCH/DECODE/EXEC/MEMWAIT
Done  output  1  program finished (Ack level)
InstCount  output  CNT_W  retired instructions, saturating
CycleCount  output  CNT_W  busy cycles, saturating

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEMWAIT, DONE. Reset puts the block in IDLE, drives every output to 0, and clears both counters to 0. Reset has priority over all other events, including mid-MEMWAIT; MemRe drops the cycle after Reset is sampled.
- IDLE:
  - Start=1: PcClear=1 this cycle (Mealy), counters clear, next state FETCH.
  - Otherwise stay in IDLE.
- FETCH: FetchEn=1, IrLoad=1; next state DECODE.
- DECODE: no strobes asserted. AckInst=1 -> DONE; otherwise -> EXEC.
- EXEC, non-load:
  - RegWe=RegWrEn, MemWe=MemWrEn.
  - PcBranch=BranchEn&Taken, PcInc=!(BranchEn&Taken).
  - Next state FETCH.
  - A taken branch never writes the register file: RegWe forced to 0 when BranchEn=1.
- EXEC, load (LoadInst=1):
  - MemRe=1, RegWe=0, MemWe=0 (LoadInst has priority over MemWrEn).
  - Wait counter loads MEM_LAT-1; next state MEMWAIT.
- MEMWAIT:
  - MemRe=1; decrement wait counter each cycle.
  - In the cycle the counter reads 0: RegWe=1, PcInc=1, next state FETCH.
  - A load occupies EXEC plus MEM_LAT cycles of MEMWAIT.
- Latency per instruction: non-load 3 cycles; load 3+MEM_LAT; done instruction 2 cycles then DONE.
- DONE: Done=1, Busy=0, all strobes 0, counters hold. Start=0 -> IDLE. Start held at 1 -> stay in DONE, so a new run needs Start to drop and rise again.
- Start deasserting while Busy is ignored; the run continues to DONE.
- InstCount increments in any cycle with PcInc|PcBranch; the done instruction is not counted.
- CycleCount increments every cycle Busy=1.
- Both counters saturate at all-ones with no wrap. Both clear on the IDLE->FETCH transition and on Reset.
- Decoder flags and Taken are sampled only in DECODE/EXEC/MEMWAIT; their values in other states have no effect.

Decomposition:
- Definitions package:
  - seq_state_t enum (3 bits, the six states)
  - SEQ_CNT_W default constant
- Sub-module sat_counter (parameter W; inputs clr, inc; output count saturating at 2^W-1). Instantiated twice, for InstCount and CycleCount.
- The wait counter is local: width $clog2(MEM_LAT+1).

Test Plan:
- Reset, then Start=1 with RegWrEn=1 held:
  - PcClear=1 in cycle 0.
  - FETCH cycle 1 with FetchEn=IrLoad=1.
  - EXEC cycle 3 with RegWe=PcInc=1.
  - InstCount=1 after cycle 3; CycleCount=3.
- Load, MEM_LAT=2, LoadInst=1 and MemWrEn=1:
  - MemRe=1 in cycles 3,4,5; MemWe never asserts.
  - RegWe=PcInc=1 only in cycle 5; next FETCH in cycle 6.
- Branch:
  - BranchEn=1, RegWrEn=1, Taken=1 -> EXEC shows PcBranch=1, PcInc=0, RegWe=0.
  - Repeat with Taken=0 -> PcInc=1, PcBranch=0.
  - InstCount increments in both cases.
- Done and restart:
  - AckInst=1 in DECODE -> DONE next cycle, Done=1, Busy=0, InstCount unchanged.
  - Start held 5 cycles -> stays in DONE.
  - Start=0 -> IDLE.
  - Start=1 -> PcClear pulse, counters read 0.
- Reset mid-operation: assert Reset during the first MEMWAIT cycle -> next cycle IDLE, MemRe=0, all outputs 0, counters 0.
- Saturation, CNT_W=4, continuous RegWrEn instructions for 30 cycles -> CycleCount=15 and holds; InstCount=10.
